// File: rtl/lfsr_gen.sv
// lfsr_gen: parameterisable Fibonacci/Galois LFSR with load, wrap detection and period measurement.
// Latency: zero added; a step or load is visible on o_lfsr at the edge where i_en/i_load is sampled.
// Backpressure: none; the register advances on every cycle with i_en=1 and holds otherwise.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset (overrides load and enable)
//   i_en      advance one step
//   i_load    load i_seed (takes priority over i_en)
//   i_seed    load value; all-zero is rejected and replaced by SEED
//   o_lfsr    current state
//   o_bit     serial output, o_lfsr[WIDTH-1]
//   o_wrap    one-cycle pulse when a step lands back on the start value
//   o_period  step count of the last completed cycle
//   o_lockup  one-cycle pulse when an all-zero seed was rejected
module lfsr_gen #(
  parameter int unsigned      WIDTH  = 4,
  parameter logic [WIDTH-1:0] POLY   = 4'b1001,
  parameter logic [WIDTH-1:0] SEED   = 4'b0001,
  parameter bit               GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_lfsr,
  output logic             o_bit,
  output logic             o_wrap,
  output logic [WIDTH-1:0] o_period,
  output logic             o_lockup
);

  // Fibonacci taps: POLY[k] selects state bit WIDTH-1-k, i.e. POLY bit-reversed.
  localparam logic [WIDTH-1:0] POLY_REV = {<<{POLY}};

  logic [WIDTH-1:0] lfsr_q,   lfsr_d;
  logic [WIDTH-1:0] start_q,  start_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q,   wrap_d;
  logic             lockup_q, lockup_d;

  logic             fb;
  logic [WIDTH-1:0] step_raw;
  logic [WIDTH-1:0] step_val;

  always_comb begin
    fb       = ^(lfsr_q & POLY_REV);
    step_raw = '0;
    if (GALOIS) begin
      step_raw = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? POLY : '0);
    end else begin
      step_raw = {lfsr_q[WIDTH-2:0], fb};
    end
    // A degenerate POLY (no x^0 term) can collapse to zero; recover via SEED
    // so the register never sticks in the all-zero lockup state.
    step_val = (step_raw == '0) ? SEED : step_raw;
  end

  always_comb begin
    lfsr_d   = lfsr_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (i_load) begin
      // Load wins over enable: no step, no count, no wrap this cycle.
      if (i_seed == '0) begin
        lfsr_d   = SEED;
        start_d  = SEED;
        lockup_d = 1'b1;
      end else begin
        lfsr_d  = i_seed;
        start_d = i_seed;
      end
      cnt_d = '0;
    end else if (i_en) begin
      lfsr_d = step_val;
      if (step_val == start_q) begin
        // cnt_q counts steps already taken; this step closes the cycle.
        wrap_d   = 1'b1;
        period_d = cnt_q + WIDTH'(1);
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q   <= SEED;
      start_q  <= SEED;
      cnt_q    <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign o_lfsr   = lfsr_q;
  assign o_bit    = lfsr_q[WIDTH-1];
  assign o_wrap   = wrap_q;
  assign o_period = period_q;
  assign o_lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench for lfsr_gen, Fibonacci (defaults) and Galois instances.
// Latency: expectations are pushed when a cycle is driven and popped one edge later.
// Backpressure: none; the bench drives one input vector per clock.
module tb_lfsr_gen;

  typedef struct packed {
    logic [3:0] lfsr;
    logic [3:0] period;
    logic       wrap;
    logic       lockup;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       f_reset = 1'b1, f_en = 1'b0, f_load = 1'b0;
  logic [3:0] f_seed  = 4'h0;
  logic [3:0] f_lfsr, f_period;
  logic       f_bit, f_wrap, f_lockup;

  logic       g_reset = 1'b1, g_en = 1'b0, g_load = 1'b0;
  logic [3:0] g_seed  = 4'h0;
  logic [3:0] g_lfsr, g_period;
  logic       g_bit, g_wrap, g_lockup;

  lfsr_gen u_fib (
    .clk(clk), .reset(f_reset), .i_en(f_en), .i_load(f_load), .i_seed(f_seed),
    .o_lfsr(f_lfsr), .o_bit(f_bit), .o_wrap(f_wrap), .o_period(f_period), .o_lockup(f_lockup)
  );

  lfsr_gen #(.WIDTH(4), .POLY(4'b1001), .SEED(4'b0001), .GALOIS(1'b1)) u_gal (
    .clk(clk), .reset(g_reset), .i_en(g_en), .i_load(g_load), .i_seed(g_seed),
    .o_lfsr(g_lfsr), .o_bit(g_bit), .o_wrap(g_wrap), .o_period(g_period), .o_lockup(g_lockup)
  );

  // Maximal-length orbits of x^4+x^3+1 starting at 0001.
  logic [3:0] fib_tab [15];
  logic [3:0] gal_tab [15];

  int n_vec = 0;
  int n_err = 0;

  exp_t fq[$];
  exp_t gq[$];

  // Index-based reference model for the Fibonacci instance.
  int m_pos = 0, m_start = 0, m_cnt = 0, m_per = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 15; i++) if (fib_tab[i] == v) return i;
    return 0;
  endfunction

  task automatic apply_fib(input string tag, input bit rst, input bit load,
                           input bit en, input logic [3:0] seed);
    exp_t e;
    e.wrap   = 1'b0;
    e.lockup = 1'b0;
    if (rst) begin
      m_pos = 0; m_start = 0; m_cnt = 0; m_per = 0;
    end else if (load) begin
      if (seed == 4'h0) begin
        m_pos    = 0;
        e.lockup = 1'b1;
      end else begin
        m_pos = idx_of(seed);
      end
      m_start = m_pos;
      m_cnt   = 0;
    end else if (en) begin
      m_pos = (m_pos + 1) % 15;
      m_cnt++;
      if (m_pos == m_start) begin
        e.wrap = 1'b1;
        m_per  = m_cnt % 16;
        m_cnt  = 0;
      end
    end
    e.lfsr   = fib_tab[m_pos];
    e.period = 4'(m_per);
    fq.push_back(e);

    f_reset = rst; f_load = load; f_en = en; f_seed = seed;
    @(posedge clk);
    #1;
    if (fq.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty, got %0h, want an entry", tag, f_lfsr);
    end else begin
      e = fq.pop_front();
      chk({tag, " lfsr"},   32'(f_lfsr),   32'(e.lfsr));
      chk({tag, " bit"},    32'(f_bit),    32'(e.lfsr[3]));
      chk({tag, " wrap"},   32'(f_wrap),   32'(e.wrap));
      chk({tag, " lockup"}, 32'(f_lockup), 32'(e.lockup));
      chk({tag, " period"}, 32'(f_period), 32'(e.period));
    end
  endtask

  task automatic apply_gal(input string tag, input bit rst, input bit en, input exp_t e_in);
    exp_t e;
    gq.push_back(e_in);
    g_reset = rst; g_en = en;
    @(posedge clk);
    #1;
    if (gq.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty, got %0h, want an entry", tag, g_lfsr);
    end else begin
      e = gq.pop_front();
      chk({tag, " lfsr"},   32'(g_lfsr),   32'(e.lfsr));
      chk({tag, " bit"},    32'(g_bit),    32'(e.lfsr[3]));
      chk({tag, " wrap"},   32'(g_wrap),   32'(e.wrap));
      chk({tag, " lockup"}, 32'(g_lockup), 32'(e.lockup));
      chk({tag, " period"}, 32'(g_period), 32'(e.period));
    end
  endtask

  initial begin
    exp_t ge;
    fib_tab = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
    gal_tab = '{4'h2, 4'h4, 4'h8, 4'h9, 4'hB, 4'hF, 4'h7, 4'hE,
                4'h5, 4'hA, 4'hD, 4'h3, 4'h6, 4'hC, 4'h1};

    // Galois instance: reset, then 15 steps back to 0001 with period 15.
    ge = '{lfsr: 4'h1, period: 4'h0, wrap: 1'b0, lockup: 1'b0};
    apply_gal("gal reset", 1'b1, 1'b0, ge);
    for (int i = 0; i < 15; i++) begin
      ge.lfsr   = gal_tab[i];
      ge.wrap   = (i == 14);
      ge.period = (i == 14) ? 4'd15 : 4'd0;
      apply_gal($sformatf("gal step%0d", i + 1), 1'b0, 1'b1, ge);
    end
    g_en = 1'b0;

    // Reset while load and enable are also asserted.
    apply_fib("fib reset+load+en", 1'b1, 1'b1, 1'b1, 4'hA);
    for (int i = 0; i < 15; i++)
      apply_fib($sformatf("fib step%0d", i + 1), 1'b0, 1'b0, 1'b1, 4'h0);

    // Zero seed rejected: SEED loaded, lockup pulse, period untouched.
    apply_fib("load zero", 1'b0, 1'b1, 1'b0, 4'h0);
    apply_fib("idle after lockup", 1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 15; i++)
      apply_fib($sformatf("post-lockup step%0d", i + 1), 1'b0, 1'b0, 1'b1, 4'h0);

    // Load with enable: load only, then 15 steps to wrap.
    apply_fib("load 1010 + en", 1'b0, 1'b1, 1'b1, 4'hA);
    for (int i = 0; i < 15; i++)
      apply_fib($sformatf("from1010 step%0d", i + 1), 1'b0, 1'b0, 1'b1, 4'h0);

    // Enable toggling: idle cycles hold state and count.
    for (int i = 0; i < 15; i++) begin
      apply_fib($sformatf("toggle en step%0d", i + 1), 1'b0, 1'b0, 1'b1, 4'h0);
      if (i < 6) apply_fib($sformatf("toggle idle%0d", i + 1), 1'b0, 1'b0, 1'b0, 4'h0);
    end

    // Reset mid-sequence after step 7, then restart from 0011.
    for (int i = 0; i < 7; i++)
      apply_fib($sformatf("pre-reset step%0d", i + 1), 1'b0, 1'b0, 1'b1, 4'h0);
    apply_fib("mid reset", 1'b1, 1'b0, 1'b1, 4'h0);
    for (int i = 0; i < 3; i++)
      apply_fib($sformatf("restart step%0d", i + 1), 1'b0, 1'b0, 1'b1, 4'h0);

    f_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
